// File: rtl/seg_scan_decoder_if.sv
// rtl/seg_scan_decoder_if.sv - scanned 7-segment display bus and decoded frame outputs
interface seg_scan_decoder_if;
    logic [3:0]  AN;
    logic [7:0]  segs;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [3:0]  minus;
    logic [3:0]  blank;
    logic        bad_code;
    logic        frame_valid;
    logic        timeout;

    modport master (
        output AN, segs,
        input  digits, dp, minus, blank, bad_code, frame_valid, timeout
    );

    modport slave (
        input  AN, segs,
        output digits, dp, minus, blank, bad_code, frame_valid, timeout
    );
endinterface

// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - decodes a multiplexed 4-digit 7-segment scan into hex nibbles
// Optional frame watchdog enabled by SEG_SCAN_TIMEOUT_EN.
module seg_scan_decoder #(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic               CLK_in,
    input  logic               rst,
    seg_scan_decoder_if.slave  bus
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_HOLD   = 2'd2;
    localparam logic [7:0] STABLE_W = 8'(STABLE_CYCLES);

    if (STABLE_CYCLES < 2 || STABLE_CYCLES > 255 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("seg_scan_decoder: parameter out of range");
    end

    logic [3:0]  an_s1_q, an_s1_d, an_s2_q, an_s2_d;
    logic [7:0]  segs_s1_q, segs_s1_d, segs_s2_q, segs_s2_d;
    logic [11:0] prev_q, prev_d;
    logic [1:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [3:0]  seen_q, seen_d;
    logic [15:0] sh_dig_q, sh_dig_d;
    logic [3:0]  sh_dp_q, sh_dp_d, sh_minus_q, sh_minus_d, sh_blank_q, sh_blank_d;
    logic        sh_bad_q, sh_bad_d;
    logic [15:0] digits_q, digits_d;
    logic [3:0]  dp_q, dp_d, minus_q, minus_d, blank_q, blank_d;
    logic        bad_code_q, bad_code_d;
    logic        frame_valid_q, frame_valid_d;

    logic        legal;
    logic [1:0]  slot;
    logic        capture;
    logic        frame_done;
    logic        clear_shadow;
    logic [6:0]  dec;

    // Returns {nibble, minus, blank, bad} for an active-high gfedcba pattern.
    function automatic logic [6:0] decode(input logic [6:0] code);
        case (code)
            7'h3F: decode = {4'h0, 3'b000};
            7'h06: decode = {4'h1, 3'b000};
            7'h5B: decode = {4'h2, 3'b000};
            7'h4F: decode = {4'h3, 3'b000};
            7'h66: decode = {4'h4, 3'b000};
            7'h6D: decode = {4'h5, 3'b000};
            7'h7D: decode = {4'h6, 3'b000};
            7'h07: decode = {4'h7, 3'b000};
            7'h7F: decode = {4'h8, 3'b000};
            7'h6F: decode = {4'h9, 3'b000};
            7'h77: decode = {4'hA, 3'b000};
            7'h7C: decode = {4'hB, 3'b000};
            7'h39: decode = {4'hC, 3'b000};
            7'h5E: decode = {4'hD, 3'b000};
            7'h79: decode = {4'hE, 3'b000};
            7'h71: decode = {4'hF, 3'b000};
            7'h40: decode = {4'h0, 3'b100};
            7'h00: decode = {4'h0, 3'b010};
            default: decode = {4'h0, 3'b001};
        endcase
    endfunction

    always_comb begin
        legal = 1'b1;
        slot  = 2'd0;
        case (an_s2_q)
            4'b1110: slot = 2'd0;
            4'b1101: slot = 2'd1;
            4'b1011: slot = 2'd2;
            4'b0111: slot = 2'd3;
            default: legal = 1'b0;
        endcase
    end

    assign dec        = decode(~segs_s2_q[6:0]);
    assign frame_done = (seen_q == 4'b1111);

`ifdef SEG_SCAN_TIMEOUT_EN
    logic [31:0] wd_q, wd_d;
    logic        timeout_q, timeout_d;

    // The watchdog restarts on each completed frame and drops any partial frame on expiry.
    always_comb begin
        wd_d         = wd_q + 32'd1;
        timeout_d    = 1'b0;
        clear_shadow = 1'b0;
        if (frame_done) begin
            wd_d = 32'd0;
        end else if (wd_q == 32'(TIMEOUT_CYCLES - 1)) begin
            wd_d         = 32'd0;
            timeout_d    = 1'b1;
            clear_shadow = 1'b1;
        end
    end

    always_ff @(posedge CLK_in or posedge rst) begin
        if (rst) begin
            wd_q      <= 32'd0;
            timeout_q <= 1'b0;
        end else begin
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.timeout = timeout_q;
`else
    assign clear_shadow = 1'b0;
    assign bus.timeout  = 1'b0;
`endif

    always_comb begin
        an_s1_d    = bus.AN;
        an_s2_d    = an_s1_q;
        segs_s1_d  = bus.segs;
        segs_s2_d  = segs_s1_q;
        prev_d     = {an_s2_q, segs_s2_q};
        state_d    = state_q;
        cnt_d      = cnt_q;
        capture    = 1'b0;
        sh_dig_d   = sh_dig_q;
        sh_dp_d    = sh_dp_q;
        sh_minus_d = sh_minus_q;
        sh_blank_d = sh_blank_q;
        digits_d   = digits_q;
        dp_d       = dp_q;
        minus_d    = minus_q;
        blank_d    = blank_q;
        bad_code_d = bad_code_q;
        frame_valid_d = frame_done;

        if (!legal) begin
            state_d = S_IDLE;
            cnt_d   = 8'd0;
        end else if (state_q == S_IDLE || {an_s2_q, segs_s2_q} != prev_q) begin
            state_d = S_SETTLE;
            cnt_d   = 8'd1;
        end else if (state_q == S_SETTLE) begin
            cnt_d = cnt_q + 8'd1;
            if (cnt_q + 8'd1 == STABLE_W) begin
                state_d = S_HOLD;
                capture = 1'b1;
            end
        end

        // A completed frame clears the mask first so a same-cycle capture opens the next frame.
        seen_d   = (frame_done || clear_shadow) ? 4'b0000 : seen_q;
        sh_bad_d = (frame_done || clear_shadow) ? 1'b0 : sh_bad_q;

        if (capture) begin
            seen_d[slot]               = 1'b1;
            sh_dig_d[{slot, 2'b00} +: 4] = dec[6:3];
            sh_minus_d[slot]           = dec[2];
            sh_blank_d[slot]           = dec[1];
            sh_dp_d[slot]              = ~segs_s2_q[7];
            sh_bad_d                   = sh_bad_d | dec[0];
        end

        if (frame_done) begin
            digits_d   = sh_dig_q;
            dp_d       = sh_dp_q;
            minus_d    = sh_minus_q;
            blank_d    = sh_blank_q;
            bad_code_d = sh_bad_q;
        end
    end

    always_ff @(posedge CLK_in or posedge rst) begin
        if (rst) begin
            an_s1_q       <= 4'h0;
            an_s2_q       <= 4'h0;
            segs_s1_q     <= 8'h00;
            segs_s2_q     <= 8'h00;
            prev_q        <= 12'h000;
            state_q       <= S_IDLE;
            cnt_q         <= 8'd0;
            seen_q        <= 4'h0;
            sh_dig_q      <= 16'h0000;
            sh_dp_q       <= 4'h0;
            sh_minus_q    <= 4'h0;
            sh_blank_q    <= 4'h0;
            sh_bad_q      <= 1'b0;
            digits_q      <= 16'h0000;
            dp_q          <= 4'h0;
            minus_q       <= 4'h0;
            blank_q       <= 4'h0;
            bad_code_q    <= 1'b0;
            frame_valid_q <= 1'b0;
        end else begin
            an_s1_q       <= an_s1_d;
            an_s2_q       <= an_s2_d;
            segs_s1_q     <= segs_s1_d;
            segs_s2_q     <= segs_s2_d;
            prev_q        <= prev_d;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            seen_q        <= seen_d;
            sh_dig_q      <= sh_dig_d;
            sh_dp_q       <= sh_dp_d;
            sh_minus_q    <= sh_minus_d;
            sh_blank_q    <= sh_blank_d;
            sh_bad_q      <= sh_bad_d;
            digits_q      <= digits_d;
            dp_q          <= dp_d;
            minus_q       <= minus_d;
            blank_q       <= blank_d;
            bad_code_q    <= bad_code_d;
            frame_valid_q <= frame_valid_d;
        end
    end

    assign bus.digits      = digits_q;
    assign bus.dp          = dp_q;
    assign bus.minus       = minus_q;
    assign bus.blank       = blank_q;
    assign bus.bad_code    = bad_code_q;
    assign bus.frame_valid = frame_valid_q;

endmodule

// File: doc/seg_scan_decoder.md
SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4: consecutive identical synchronized samples needed to accept a digit (legal range 2..255).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 200000: cycles without a completed frame before timeout (used only with REQ-026).
REQ-003 SHALL use one clock and an asynchronous, active-high reset; ports are CLK_in and rst.
REQ-004 CLK_in  input  1  system clock; rising-edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 AN  input  4  digit anodes, active-low; AN[i]=0 selects slot i.
REQ-007 segs  input  8  segment lines, active-low; segs[6:0]=g..a, segs[7]=dp.
REQ-008 digits  output  16  decoded hex nibbles; slot i in digits[4i+3:4i].
REQ-009 dp  output  4  decimal point lit, per slot.
REQ-010 minus  output  4  slot showed '-' (g only).
REQ-011 blank  output  4  slot showed no segments.
REQ-012 bad_code  output  1  at least one slot in the last frame held an undecodable pattern.
REQ-013 frame_valid  output  1  one-cycle pulse when the frame outputs update.
REQ-014 timeout  output  1  one-cycle pulse on watchdog expiry.

Function
REQ-015 AN and segs SHALL pass through a 2-flop synchronizer; all decoding SHALL use the synchronized values.
REQ-016 A sample SHALL be legal only if exactly one AN bit is 0; otherwise the FSM SHALL go to IDLE and clear the stability counter.
REQ-017 The FSM SHALL have states IDLE, SETTLE and HOLD. IDLE goes to SETTLE on a legal sample. SETTLE counts identical {AN,segs} samples, restarts at 1 on any change, and goes to HOLD when the count reaches STABLE_CYCLES. HOLD returns to SETTLE on any {AN,segs} change and to IDLE on an illegal AN.
REQ-018 On entry to HOLD, the selected slot SHALL be captured into a shadow register and its seen-mask bit set. A re-capture of a slot already seen SHALL overwrite that slot.
REQ-019 The decode of ~segs[6:0] (gfedcba) SHALL be 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
REQ-020 The special codes SHALL be 40 (minus; nibble 0, minus=1) and 00 (blank; nibble 0, blank=1). Any other code SHALL give nibble 0 and set the shadow bad flag.
REQ-021 dp[i] SHALL equal ~segs[7] at capture.
REQ-022 When the seen mask becomes 4'b1111, on the next cycle the shadow SHALL be copied to digits/dp/minus/blank/bad_code, frame_valid SHALL pulse for 1 cycle, and the mask and shadow bad flag SHALL clear. If a capture occurs in that same cycle, it SHALL land in the cleared mask.
REQ-023 Outputs SHALL hold their values between frames.
REQ-024 Latency SHALL be: last slot stable at the pins, then frame_valid asserts 2 + STABLE_CYCLES + 1 cycles later.

Reset
REQ-025 While rst=1, the following SHALL be forced: FSM=IDLE; counters, seen mask, shadow and synchronizers cleared; digits=16'h0000, dp=minus=blank=4'h0, bad_code=0, frame_valid=0, timeout=0. Reset mid-frame SHALL discard partial captures.

Configuration
REQ-026 With SEG_SCAN_TIMEOUT_EN defined, a watchdog SHALL count cycles since reset or the last frame_valid. At TIMEOUT_CYCLES it SHALL pulse timeout for 1 cycle, clear the seen mask and shadow bad flag, and restart the count; frame outputs are unchanged.
REQ-027 Without SEG_SCAN_TIMEOUT_EN, no watchdog logic SHALL exist and timeout SHALL be tied to 0.

Verification
REQ-028 Scan AN=1110,1101,1011,0111 with ~segs=06,5B,4F,66 at 8 cycles/slot -> frame_valid pulse; digits=16'h4321, dp=0, minus=0, blank=0, bad_code=0.
REQ-029 Slot3 ~segs=40, slot2 blank 00, slot1=7F with dp lit, slot0=71 -> digits=16'h008F, minus=4'b1000, blank=4'b0100, dp=4'b0010.
REQ-030 Slot1 ~segs=2A (illegal) with other slots valid -> bad_code=1 and digits[7:4]=0; next clean frame -> bad_code=0.
REQ-031 Drive AN=1100, then glitch segs every 2 cycles with STABLE_CYCLES=4 -> no capture and no frame_valid; assert rst after 3 slots captured -> outputs 0, and the following full scan is needed for frame_valid.
REQ-032 With SEG_SCAN_TIMEOUT_EN and TIMEOUT_CYCLES=100, scan only 3 slots -> timeout pulse at cycle 100; frame outputs unchanged; without the macro -> timeout stays 0.
